// File: rtl/async_fifo_rtl_pkg.sv
// Shared types and defaults for the async FIFO read-side controller.
package async_fifo_rtl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } rd_state_e;

    // Buffer occupancy once this cycle's downstream handshake has drained a word.
    function automatic logic [1:0] occ_after_pop(input logic [1:0] count, input logic pop);
        return count - {1'b0, pop};
    endfunction

endpackage

// File: rtl/async_fifo_out_buf.sv
// Two-entry FIFO-ordered output buffer between the async FIFO read port and the stream output.
module async_fifo_out_buf
    import async_fifo_rtl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the output is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= data_in;
    end

    assign valid    = (r_count != 2'd0);
    assign data_out = valid ? r_mem[r_rptr] : '0;
    assign count    = r_count;

endmodule

// File: rtl/async_fifo_read_ctrl.sv
// Read-side controller: drains an async FIFO into a ready/valid stream through a 2-entry buffer.
module async_fifo_read_ctrl
    import async_fifo_rtl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  en,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    rd_state_e            r_state;
    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_rd_count;
    logic [1:0]           w_count;
    logic                 w_pop;
    logic [2:0]           w_pending;

    assign w_pop = m_valid && m_ready;

    // Counting the word leaving this cycle keeps one read per cycle while streaming,
    // yet a stalled sink still caps buffered plus in-flight words at two.
    assign w_pending = {1'b0, occ_after_pop(w_count, w_pop)} + {2'b00, r_inflight};
    assign fifo_rinc = (r_state == RUN) && !fifo_rempty && (w_pending < 3'd2);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
            r_rd_count <= '0;
        end else begin
            r_inflight <= fifo_rinc;
            if (w_pop) r_rd_count <= r_rd_count + 1'b1;
            case (r_state)
                IDLE: if (en) r_state <= RUN;
                RUN:  if (!en) r_state <= STOP;
                STOP: begin
                    if (en)
                        r_state <= RUN;
                    else if (!r_inflight && (w_count == 2'd0))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The word read last cycle is on fifo_rdata now and is captured at this edge.
    async_fifo_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .push    (r_inflight),
        .data_in (fifo_rdata),
        .pop     (w_pop),
        .valid   (m_valid),
        .data_out(m_data),
        .count   (w_count)
    );

    assign busy     = (r_state != IDLE);
    assign rd_count = r_rd_count;

endmodule

// File: tb/tb_async_fifo_read_ctrl.sv
// Scoreboard bench for async_fifo_read_ctrl with a behavioural async-FIFO read port model.
module tb_async_fifo_read_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b1;
    logic          en = 1'b0;
    logic          fifo_rempty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rinc;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          busy;
    logic [CW-1:0] rd_count;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] load_q [$];
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int load_rd   = 0;
    int exp_rd    = 0;
    int clr_seq   = 0;
    int clr_seen  = 0;
    int rinc_cnt  = 0;
    int hs_cnt    = 0;

    async_fifo_read_ctrl #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .en         (en),
        .fifo_rempty(fifo_rempty),
        .fifo_rdata (fifo_rdata),
        .fifo_rinc  (fifo_rinc),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .rd_count   (rd_count)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO read port: data appears the cycle after a read; garbage otherwise.
    always @(posedge rclk) begin
        if (fifo_rinc) begin
            rinc_cnt++;
            checks++;
            if (fifo_q.size() == 0) begin
                failures++;
                $display("FAIL underflow: fifo_rinc=1 with fifo_rempty=%0b, expected no read", fifo_rempty);
                fifo_rdata <= 8'hA5;
            end else begin
                fifo_rdata <= fifo_q.pop_front();
            end
        end else begin
            fifo_rdata <= 8'hA5;
        end
        if (clr_seq != clr_seen) begin
            fifo_q.delete();
            load_rd  = load_q.size();
            clr_seen = clr_seq;
        end
        while (load_rd < load_q.size()) begin
            fifo_q.push_back(load_q[load_rd]);
            load_rd++;
        end
        fifo_rempty <= (fifo_q.size() == 0);
    end

    // Monitor: pops expected words on each handshake and checks stall stability.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge rclk) begin
        if (!rrst_n) begin
            exp_rd     = exp_q.size();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", m_valid, 1);
                check("stall_hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_rd < exp_q.size()) begin
                    check("m_data_order", m_data, exp_q[exp_rd]);
                    exp_rd++;
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: got 0x%0h, expected no word", m_data);
                end
                hs_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n  = 1'b0;
        en      = 1'b0;
        m_ready = 1'b0;
        clr_seq++;
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
    endtask

    task automatic load(input logic [DW-1:0] first, input int n, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            load_q.push_back(first + DW'(i));
            if (expect_out) exp_q.push_back(first + DW'(i));
        end
    endtask

    task automatic wait_hs(input string name, input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && hs_cnt < target; i++) tick();
        check(name, hs_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int h0;
        int last_hs_t;
        int idle_t;

        // Reset values, checked before any clock edge.
        #2 rrst_n = 1'b0;
        #1;
        check("rst_rinc", fifo_rinc, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_count", rd_count, 0);
        tick();
        tick();
        rrst_n = 1'b1;
        tick();

        // Preloaded 0x01..0x08, sustained streaming.
        load(8'h01, 8, 1'b1);
        tick();
        en      = 1'b1;
        m_ready = 1'b1;
        tick();
        check("t1_first_rinc", fifo_rinc, 1);
        check("t1_lat1_valid", m_valid, 0);
        tick();
        check("t1_lat2_valid", m_valid, 0);
        tick();
        check("t1_first_data", m_data, 8'h01);
        for (int i = 0; i < 8; i++) begin
            check("t1_stream_valid", m_valid, 1);
            tick();
        end
        check("t1_rd_count", rd_count, 8);
        check("t1_drained", m_valid, 0);
        en = 1'b0;
        for (int i = 0; i < 10 && busy; i++) tick();
        check("t1_idle", busy, 0);

        // Stalled sink: only two reads, head word held.
        do_reset();
        load(8'h11, 5, 1'b1);
        r0 = rinc_cnt;
        h0 = hs_cnt;
        en = 1'b1;
        repeat (10) tick();
        check("t2_rinc_stalled", rinc_cnt - r0, 2);
        check("t2_valid_stalled", m_valid, 1);
        check("t2_head_word", m_data, 8'h11);
        m_ready = 1'b1;
        wait_hs("t2_drain_count", h0 + 5, 30);
        check("t2_rinc_total", rinc_cnt - r0, 5);

        // Empty FIFO with en=1.
        do_reset();
        r0 = rinc_cnt;
        en      = 1'b1;
        m_ready = 1'b1;
        repeat (6) tick();
        check("t3_no_rinc", rinc_cnt - r0, 0);
        check("t3_no_valid", m_valid, 0);
        check("t3_busy", busy, 1);

        // en dropped during the third read.
        do_reset();
        load(8'h21, 3, 1'b1);
        load(8'h24, 3, 1'b0);
        r0 = rinc_cnt;
        h0 = hs_cnt;
        tick();
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((rinc_cnt - r0 == 2) && fifo_rinc) break;
        end
        en        = 1'b0;
        last_hs_t = -1;
        idle_t    = -1;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (last_hs_t < 0 && hs_cnt - h0 >= 3) last_hs_t = t;
            if (!busy) begin
                idle_t = t;
                break;
            end
        end
        check("t4_words", hs_cnt - h0, 3);
        check("t4_reads", rinc_cnt - r0, 3);
        check("t4_busy_low", busy, 0);
        check("t4_idle_within_2", (idle_t >= 0 && last_hs_t >= 0 && idle_t - last_hs_t <= 2), 1);

        // Reset with two words buffered.
        do_reset();
        load(8'h31, 1, 1'b1);
        load(8'h32, 3, 1'b0);
        en = 1'b1;
        repeat (6) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (4) tick();
        check("t5_buffered_head", m_data, 8'h32);
        check("t5_rd_count_pre", rd_count, 1);
        rrst_n = 1'b0;
        #1;
        check("t5_rst_valid", m_valid, 0);
        check("t5_rst_rd_count", rd_count, 0);
        check("t5_rst_data", m_data, 0);
        check("t5_rst_busy", busy, 0);
        clr_seq++;
        en = 1'b0;
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
        check("t5_no_stale_a", m_valid, 0);
        tick();
        check("t5_no_stale_b", m_valid, 0);
        h0 = hs_cnt;
        load(8'h3A, 1, 1'b1);
        en      = 1'b1;
        m_ready = 1'b1;
        wait_hs("t5_fresh_word", h0 + 1, 12);
        check("t5_rd_count_post", rd_count, 1);

        // Counter wrap with a 4-bit counter.
        do_reset();
        load(8'h40, 17, 1'b1);
        h0 = hs_cnt;
        en      = 1'b1;
        m_ready = 1'b1;
        wait_hs("t6_words", h0 + 17, 60);
        check("t6_rd_count_wrap", rd_count, 1);
        en = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
